// File: rtl/mmcam_match_ctrl_if.sv
// Packet handshake and MMRAM command bundle of the matching-memory controller.
// The slave side is the controller; the master side is its upstream/downstream environment.
interface mmcam_match_ctrl_if #(
  parameter int TAG_W  = 19,
  parameter int ADDR_W = 6
);
  logic              Send_in;
  logic              Ack_out;
  logic              MachingFlag;
  logic [TAG_W-1:0]  tag_in;
  logic              Send_out;
  logic              Ack_in;
  logic              WR_E;
  logic              DEL;
  logic [ADDR_W-1:0] ADDR;
  logic              HIT;
  logic              FULL;
  logic              OVF;
  logic [ADDR_W:0]   COUNT;

  modport master (
    output Send_in, MachingFlag, tag_in, Ack_in,
    input  Ack_out, Send_out, WR_E, DEL, ADDR, HIT, FULL, OVF, COUNT
  );

  modport slave (
    input  Send_in, MachingFlag, tag_in, Ack_in,
    output Ack_out, Send_out, WR_E, DEL, ADDR, HIT, FULL, OVF, COUNT
  );
endinterface

// File: rtl/mmcam_match_ctrl.sv
// Allocate-or-match controller for the matching memory: one packet in flight,
// one MMRAM command (write, delete/read or bypass) per packet.
module mmcam_match_ctrl #(
  parameter int ENTRIES = 64,
  parameter int ADDR_W  = 6,
  parameter int TAG_W   = 19
) (
  input  logic                CP,
  input  logic                MR,
  mmcam_match_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_WRITE,
    S_ISSUE
  } state_t;

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(ENTRIES);

  state_t              state_q, state_d;
  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                mf_q, mf_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                ack_q, ack_d;
  logic                send_q, send_d;
  logic                wr_q, wr_d;
  logic                del_q, del_d;
  logic                hit_q, hit_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  logic [TAG_W-1:0]    tag_mem [ENTRIES];
  logic                tag_we;

  logic [ENTRIES-1:0]  match_vec;
  logic                hit_found;
  logic [ADDR_W-1:0]   hit_idx;
  logic [ADDR_W-1:0]   free_idx;
  logic                full;

  assign full = (count_q == FULL_COUNT);

  // Parallel compare of the latched tag against every valid entry.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      match_vec[i] = valid_q[i] && (tag_mem[i] == tag_q);
    end
  end

  // Priority encoders: scanning downward leaves the lowest qualifying index.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    free_idx  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        hit_found = 1'b1;
        hit_idx   = ADDR_W'(i);
      end
      if (!valid_q[i]) begin
        free_idx = ADDR_W'(i);
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold/idle value first so no path through the case leaves one unassigned (no latches).
    state_d = state_q;
    valid_d = valid_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    mf_d    = mf_q;
    tag_d   = tag_q;
    send_d  = send_q;
    hit_d   = hit_q;
    addr_d  = addr_q;
    ack_d   = 1'b0;
    wr_d    = 1'b0;
    del_d   = 1'b0;
    tag_we  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.Send_in) begin
          mf_d    = bus.MachingFlag;
          tag_d   = bus.tag_in;
          ack_d   = 1'b1;
          state_d = S_SEARCH;
        end
      end

      S_SEARCH: begin
        if (!mf_q) begin
          send_d  = 1'b1;
          hit_d   = 1'b0;
          addr_d  = '0;
          state_d = S_ISSUE;
        end else if (hit_found) begin
          del_d            = 1'b1;
          send_d           = 1'b1;
          hit_d            = 1'b1;
          addr_d           = hit_idx;
          valid_d[hit_idx] = 1'b0;
          count_d          = count_q - 1'b1;
          state_d          = S_ISSUE;
        end else if (!full) begin
          wr_d              = 1'b1;
          addr_d            = free_idx;
          valid_d[free_idx] = 1'b1;
          tag_we            = 1'b1;
          count_d           = count_q + 1'b1;
          state_d           = S_WRITE;
        end else begin
          // No room for a partner-less packet: it is dropped and flagged.
          ovf_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_WRITE: begin
        state_d = S_IDLE;
      end

      S_ISSUE: begin
        if (bus.Ack_in) begin
          send_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      mf_q    <= 1'b0;
      tag_q   <= '0;
      ack_q   <= 1'b0;
      send_q  <= 1'b0;
      wr_q    <= 1'b0;
      del_q   <= 1'b0;
      hit_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      mf_q    <= mf_d;
      tag_q   <= tag_d;
      ack_q   <= ack_d;
      send_q  <= send_d;
      wr_q    <= wr_d;
      del_q   <= del_d;
      hit_q   <= hit_d;
      addr_q  <= addr_d;
    end
  end

  // NOTE: tag storage has no reset; an entry's tag is only observed while its valid bit is set.
  always_ff @(posedge CP) begin
    if (tag_we) begin
      tag_mem[free_idx] <= tag_q;
    end
  end

  assign bus.Ack_out  = ack_q;
  assign bus.Send_out = send_q;
  assign bus.WR_E     = wr_q;
  assign bus.DEL      = del_q;
  assign bus.ADDR     = addr_q;
  assign bus.HIT      = hit_q;
  assign bus.FULL     = full;
  assign bus.OVF      = ovf_q;
  assign bus.COUNT    = count_q;

endmodule

// File: tb/tb_mmcam_match_ctrl.sv
// Scoreboard bench for mmcam_match_ctrl: drivers push expected MMRAM commands,
// a monitor pops and compares them as the controller emits strobes.
module tb_mmcam_match_ctrl;

  localparam int ENTRIES = 64;
  localparam int ADDR_W  = 6;
  localparam int TAG_W   = 19;

  typedef enum logic [1:0] {EV_WR, EV_HIT, EV_BYP, EV_DROP} ev_kind_t;

  typedef struct {
    ev_kind_t          kind;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic mr  = 1'b1;

  int checks   = 0;
  int failures = 0;
  int ack_delay = 0;

  exp_t sb[$];
  exp_t mon_e;

  mmcam_match_ctrl_if #(.TAG_W(TAG_W), .ADDR_W(ADDR_W)) bus ();

  mmcam_match_ctrl #(
    .ENTRIES(ENTRIES),
    .ADDR_W (ADDR_W),
    .TAG_W  (TAG_W)
  ) dut (
    .CP (clk),
    .MR (mr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Downstream: accepts Send_out after ack_delay cycles.
  initial begin
    int wait_cnt = 0;
    bus.Ack_in = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.Send_out) begin
        bus.Ack_in = (wait_cnt >= ack_delay);
        wait_cnt++;
      end else begin
        bus.Ack_in = 1'b0;
        wait_cnt   = 0;
      end
    end
  end

  // Monitor: compares every write strobe and every new Send_out against the scoreboard.
  initial begin
    logic              prev_send = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic              prev_hit  = 1'b0;
    forever begin
      @(negedge clk);
      if (mr) begin
        prev_send = 1'b0;
      end else begin
        if (bus.WR_E) begin
          if (sb.size() == 0) check("unexpected_wr", 1, 0);
          else begin
            mon_e = sb.pop_front();
            check("wr_kind", 32'(bus.Send_out ? EV_HIT : EV_WR), 32'(mon_e.kind));
            check("wr_addr", 32'(bus.ADDR), 32'(mon_e.addr));
          end
        end
        if (bus.DEL && !bus.Send_out) check("stray_del", 1, 0);
        if (bus.Send_out && !prev_send) begin
          if (sb.size() == 0) check("unexpected_send", 1, 0);
          else begin
            mon_e = sb.pop_front();
            check("issue_kind", 32'(bus.HIT ? EV_HIT : EV_BYP), 32'(mon_e.kind));
            check("issue_addr", 32'(bus.ADDR), 32'(mon_e.addr));
            check("issue_del", 32'(bus.DEL), 32'(mon_e.kind == EV_HIT));
          end
        end else if (bus.Send_out && prev_send) begin
          check("issue_del_once", 32'(bus.DEL), 0);
          check("issue_addr_hold", 32'(bus.ADDR), 32'(prev_addr));
          check("issue_hit_hold", 32'(bus.HIT), 32'(prev_hit));
        end
        prev_send = bus.Send_out;
        prev_addr = bus.ADDR;
        prev_hit  = bus.HIT;
      end
    end
  end

  task automatic send_pkt(input logic mf, input logic [TAG_W-1:0] tag);
    logic got = 1'b0;
    @(negedge clk);
    bus.Send_in     = 1'b1;
    bus.MachingFlag = mf;
    bus.tag_in      = tag;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.Ack_out) got = 1'b1;
    end
    check("ack_seen", 32'(got), 1);
    bus.Send_in = 1'b0;
  endtask

  task automatic wait_send_low(input int budget);
    int n = 0;
    while (bus.Send_out && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.Send_out) check("issue_timeout", 1, 0);
  endtask

  task automatic do_pkt(input logic mf, input logic [TAG_W-1:0] tag,
                        input ev_kind_t kind, input logic [ADDR_W-1:0] addr);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    if (kind != EV_DROP) sb.push_back(e);
    send_pkt(mf, tag);
    repeat (2) @(negedge clk);
    wait_send_low(200);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    mr = 1'b1;
    @(negedge clk);
    mr = 1'b0;
  endtask

  initial begin
    exp_t e;
    bus.Send_in     = 1'b0;
    bus.MachingFlag = 1'b0;
    bus.tag_in      = '0;
    mr = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_send_out", 32'(bus.Send_out), 0);
    check("rst_ack_out", 32'(bus.Ack_out), 0);
    check("rst_wr_e", 32'(bus.WR_E), 0);
    check("rst_del", 32'(bus.DEL), 0);
    check("rst_addr", 32'(bus.ADDR), 0);
    check("rst_count", 32'(bus.COUNT), 0);
    check("rst_full", 32'(bus.FULL), 0);
    check("rst_ovf", 32'(bus.OVF), 0);
    mr = 1'b0;

    // T1: reset in the middle of ISSUE wipes every entry
    do_pkt(1'b1, 19'h00055, EV_WR, 6'd0);
    do_pkt(1'b1, 19'h00066, EV_WR, 6'd1);
    check("t1_count2", 32'(bus.COUNT), 2);
    ack_delay = 1000;
    e.kind = EV_HIT;
    e.addr = 6'd0;
    sb.push_back(e);
    send_pkt(1'b1, 19'h00055);
    repeat (3) @(negedge clk);
    check("t1_in_issue", 32'(bus.Send_out), 1);
    mr = 1'b1;
    #1;
    check("t1_async_send", 32'(bus.Send_out), 0);
    check("t1_async_del", 32'(bus.DEL), 0);
    check("t1_async_wr", 32'(bus.WR_E), 0);
    check("t1_async_hit", 32'(bus.HIT), 0);
    check("t1_async_count", 32'(bus.COUNT), 0);
    @(negedge clk);
    mr = 1'b0;
    ack_delay = 0;
    do_pkt(1'b1, 19'h00123, EV_WR, 6'd0);
    do_pkt(1'b1, 19'h00066, EV_WR, 6'd1);
    check("t1_count_after", 32'(bus.COUNT), 2);

    // T2: pair write then match
    pulse_reset();
    ack_delay = 3;
    do_pkt(1'b1, 19'h1ABCD, EV_WR, 6'd0);
    check("t2_count1", 32'(bus.COUNT), 1);
    do_pkt(1'b1, 19'h1ABCD, EV_HIT, 6'd0);
    check("t2_count0", 32'(bus.COUNT), 0);
    ack_delay = 0;

    // T3: lowest free entry is reused
    do_pkt(1'b1, 19'd1, EV_WR, 6'd0);
    do_pkt(1'b1, 19'd2, EV_WR, 6'd1);
    do_pkt(1'b1, 19'd3, EV_WR, 6'd2);
    do_pkt(1'b1, 19'd2, EV_HIT, 6'd1);
    check("t3_count2", 32'(bus.COUNT), 2);
    do_pkt(1'b1, 19'd9, EV_WR, 6'd1);
    check("t3_count3", 32'(bus.COUNT), 3);

    // T4: bypass ignores a stored equal tag
    do_pkt(1'b1, 19'h00005, EV_WR, 6'd3);
    do_pkt(1'b0, 19'h00005, EV_BYP, 6'd0);
    check("t4_count", 32'(bus.COUNT), 4);

    // T5: fill, overflow drop, then free one entry
    pulse_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      do_pkt(1'b1, 19'(i), EV_WR, 6'(i));
    end
    check("t5_full", 32'(bus.FULL), 1);
    check("t5_count64", 32'(bus.COUNT), 64);
    check("t5_ovf_before", 32'(bus.OVF), 0);
    do_pkt(1'b1, 19'd100, EV_DROP, 6'd0);
    check("t5_ovf", 32'(bus.OVF), 1);
    check("t5_count_drop", 32'(bus.COUNT), 64);
    do_pkt(1'b1, 19'd7, EV_HIT, 6'd7);
    check("t5_full_clear", 32'(bus.FULL), 0);
    check("t5_count63", 32'(bus.COUNT), 63);
    check("t5_ovf_sticky", 32'(bus.OVF), 1);

    // T6: backpressure in ISSUE with upstream still offering
    ack_delay = 10;
    e.kind = EV_HIT;
    e.addr = 6'd8;
    sb.push_back(e);
    send_pkt(1'b1, 19'd8);
    @(negedge clk);
    check("t6_send", 32'(bus.Send_out), 1);
    bus.Send_in     = 1'b1;
    bus.MachingFlag = 1'b1;
    bus.tag_in      = 19'd20;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t6_no_ack", 32'(bus.Ack_out), 0);
    end
    bus.Send_in = 1'b0;
    wait_send_low(100);
    @(negedge clk);
    check("t6_count", 32'(bus.COUNT), 62);
    ack_delay = 0;

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
